// File: rtl/recip_div_arbiter.sv
// Round-robin front end sharing one reciprocal divider among NUM_REQ requesters.
// A tag FIFO records requester indices in issue order to route results back.
module recip_div_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 32,
    parameter int MAX_OUT = 8
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [NUM_REQ*DATA_W-1:0]   req_s_data,
    input  logic [NUM_REQ-1:0]          req_s_valid,
    output logic [NUM_REQ-1:0]          req_s_ready,
    output logic [DATA_W-1:0]           resp_m_data,
    output logic [NUM_REQ-1:0]          resp_m_valid,
    input  logic [NUM_REQ-1:0]          resp_m_ready,
    output logic [DATA_W-1:0]           div_m_data,
    output logic                        div_m_valid,
    input  logic                        div_m_ready,
    input  logic [DATA_W-1:0]           div_s_data,
    input  logic                        div_s_valid,
    output logic                        div_s_ready,
    output logic [$clog2(MAX_OUT):0]    outstanding,
    output logic                        orphan_err
);

    localparam int RW = $clog2(NUM_REQ);
    localparam int PW = $clog2(MAX_OUT);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(MAX_OUT);
    localparam logic [RW:0]   NREQ_W   = (RW+1)'(NUM_REQ);
    localparam logic [RW-1:0] LAST_REQ = RW'(NUM_REQ - 1);

    logic [RW-1:0] rr_ptr_q, rr_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          orphan_q, orphan_d;
    logic [RW-1:0] tag_q [MAX_OUT];

    logic [DATA_W-1:0] req_data [NUM_REQ];
    logic              grant_found;
    logic [RW-1:0]     grant_idx;
    logic              fifo_full, fifo_empty;
    logic              issue_en, grant_vld;
    logic [RW-1:0]     head;
    logic              push, pop;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req_data[g] = req_s_data[g*DATA_W +: DATA_W];
    end

    assign fifo_full  = (count_q == FULL_CNT);
    assign fifo_empty = (count_q == '0);

    // Search starts at rr_ptr and wraps; the sum is one bit wider so the wrap
    // works for non-power-of-two requester counts.
    always_comb begin
        logic [RW:0] sum;
        grant_found = 1'b0;
        grant_idx   = '0;
        sum         = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, rr_ptr_q} + (RW+1)'(k);
            if (sum >= NREQ_W) begin
                sum = sum - NREQ_W;
            end
            if (!grant_found && req_s_valid[sum[RW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = sum[RW-1:0];
            end
        end
    end

    // A full FIFO blocks issue regardless of a same-cycle pop.
    assign issue_en    = rstn && div_m_ready && !fifo_full;
    assign grant_vld   = issue_en && grant_found;
    assign req_s_ready = grant_vld ? (NUM_REQ'(1) << grant_idx) : '0;
    assign div_m_valid = grant_vld;
    assign div_m_data  = req_data[grant_idx];
    assign push        = grant_vld;

    assign head         = tag_q[rd_ptr_q];
    assign resp_m_data  = div_s_data;
    assign resp_m_valid = (!fifo_empty && div_s_valid) ? (NUM_REQ'(1) << head) : '0;
    assign div_s_ready  = fifo_empty ? 1'b1 : resp_m_ready[head];
    assign pop          = !fifo_empty && div_s_valid && div_s_ready;

    assign outstanding = count_q;
    assign orphan_err  = orphan_q;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_vld) begin
            rr_ptr_d = (grant_idx == LAST_REQ) ? '0 : grant_idx + 1'b1;
        end

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        orphan_d = orphan_q | (fifo_empty && div_s_valid);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            orphan_q <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            orphan_q <= orphan_d;
        end
    end

    // Tag storage needs no reset: entries are only read while count_q is non-zero.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_q[wr_ptr_q] <= grant_idx;
        end
    end

endmodule

// File: tb/tb_recip_div_arbiter.sv
// Directed and random checks of recip_div_arbiter against a queue-based
// model of the arbitration and in-order return rules.
module tb_recip_div_arbiter;

    localparam int NR = 3;
    localparam int DW = 32;
    localparam int MO = 8;
    localparam int CW = $clog2(MO) + 1;

    logic              clk = 1'b0;
    logic              rstn;
    logic [NR*DW-1:0]  req_s_data;
    logic [NR-1:0]     req_s_valid;
    logic [NR-1:0]     req_s_ready;
    logic [DW-1:0]     resp_m_data;
    logic [NR-1:0]     resp_m_valid;
    logic [NR-1:0]     resp_m_ready;
    logic [DW-1:0]     div_m_data;
    logic              div_m_valid;
    logic              div_m_ready;
    logic [DW-1:0]     div_s_data;
    logic              div_s_valid;
    logic              div_s_ready;
    logic [CW-1:0]     outstanding;
    logic              orphan_err;

    recip_div_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .MAX_OUT(MO)) dut (
        .clk(clk), .rstn(rstn),
        .req_s_data(req_s_data), .req_s_valid(req_s_valid), .req_s_ready(req_s_ready),
        .resp_m_data(resp_m_data), .resp_m_valid(resp_m_valid), .resp_m_ready(resp_m_ready),
        .div_m_data(div_m_data), .div_m_valid(div_m_valid), .div_m_ready(div_m_ready),
        .div_s_data(div_s_data), .div_s_valid(div_s_valid), .div_s_ready(div_s_ready),
        .outstanding(outstanding), .orphan_err(orphan_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference state: issued tags in order, round-robin start, sticky orphan flag.
    int q[$];
    int rr = 0;
    bit orphan = 1'b0;

    logic [NR-1:0] obs_rdy, obs_rv;
    logic [DW-1:0] obs_rd;
    logic [CW-1:0] obs_out;
    logic          obs_dsr, obs_orph;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: predict, check before the edge, then advance the model at the edge.
    task automatic cycle();
        int g;
        int h;
        int idx;
        logic [NR-1:0] e_rdy;
        logic [NR-1:0] e_rv;
        logic e_dsr;
        bit do_pop;
        bit do_orph;
        if (!rstn) begin
            q.delete();
            rr = 0;
            orphan = 1'b0;
        end
        g = -1;
        if (rstn && div_m_ready && q.size() < MO) begin
            for (int k = 0; k < NR; k++) begin
                idx = (rr + k) % NR;
                if (g < 0 && req_s_valid[idx]) g = idx;
            end
        end
        e_rdy = (g >= 0) ? (NR'(1) << g) : '0;
        if (q.size() > 0) begin
            h = q[0];
            e_rv  = div_s_valid ? (NR'(1) << h) : '0;
            e_dsr = resp_m_ready[h];
        end else begin
            e_rv  = '0;
            e_dsr = 1'b1;
        end
        #3;
        obs_rdy = req_s_ready; obs_rv = resp_m_valid; obs_rd = resp_m_data;
        obs_out = outstanding; obs_dsr = div_s_ready; obs_orph = orphan_err;
        check("req_s_ready", 64'(req_s_ready), 64'(e_rdy));
        check("div_m_valid", 64'(div_m_valid), 64'(g >= 0));
        if (g >= 0) check("div_m_data", 64'(div_m_data), 64'(req_s_data[g*DW +: DW]));
        check("resp_m_valid", 64'(resp_m_valid), 64'(e_rv));
        check("resp_m_data", 64'(resp_m_data), 64'(div_s_data));
        check("div_s_ready", 64'(div_s_ready), 64'(e_dsr));
        check("outstanding", 64'(outstanding), 64'(q.size()));
        check("orphan_err", 64'(orphan_err), 64'(orphan));
        do_pop  = rstn && q.size() > 0 && div_s_valid && e_dsr;
        do_orph = rstn && q.size() == 0 && div_s_valid;
        @(posedge clk);
        if (do_pop) void'(q.pop_front());
        if (do_orph) orphan = 1'b1;
        if (rstn && g >= 0) begin
            q.push_back(g);
            rr = (g + 1) % NR;
        end
        #1;
    endtask

    task automatic idle_inputs();
        req_s_valid = '0; req_s_data = '0; resp_m_ready = '1;
        div_m_ready = 1'b1; div_s_valid = 1'b0; div_s_data = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rstn = 1'b0;
        cycle();
        cycle();
        rstn = 1'b1;
    endtask

    int ord[6] = '{0, 1, 2, 0, 1, 2};

    initial begin
        rstn = 1'b0;
        idle_inputs();
        @(posedge clk);
        #1;
        // Outputs held quiet in reset even with requests pending
        req_s_valid = '1;
        cycle();
        check("rst_rdy", 64'(obs_rdy), 64'(0));
        check("rst_out", 64'(obs_out), 64'(0));

        // Round-robin order with every requester valid
        do_reset();
        req_s_valid = '1;
        for (int i = 0; i < 6; i++) begin
            req_s_data = {DW'(32'h300 + i), DW'(32'h200 + i), DW'(32'h100 + i)};
            cycle();
            check("rr_order", 64'(obs_rdy), 64'(1) << ord[i]);
        end

        // Results return to the requester that issued them, in order
        do_reset();
        req_s_valid = 3'b001; req_s_data[0 +: DW] = 32'h0002_0000;
        cycle();
        req_s_valid = 3'b100; req_s_data[2*DW +: DW] = 32'h0004_0000;
        cycle();
        req_s_valid = '0;
        div_s_valid = 1'b1; div_s_data = 32'h0000_8000;
        cycle();
        check("ret0_vld", 64'(obs_rv), 64'(3'b001));
        check("ret0_dat", 64'(obs_rd), 64'(32'h0000_8000));
        div_s_data = 32'h0000_4000;
        cycle();
        check("ret2_vld", 64'(obs_rv), 64'(3'b100));
        check("ret2_dat", 64'(obs_rd), 64'(32'h0000_4000));
        div_s_valid = 1'b0;
        cycle();

        // Full FIFO blocks issue, including on the pop cycle
        do_reset();
        req_s_valid = '1;
        for (int i = 0; i < MO; i++) cycle();
        cycle();
        check("full_out", 64'(obs_out), 64'(MO));
        check("full_rdy", 64'(obs_rdy), 64'(0));
        div_s_valid = 1'b1; div_s_data = 32'h1234;
        cycle();
        check("pop_blk", 64'(obs_rdy), 64'(0));
        div_s_valid = 1'b0;
        cycle();
        check("pop_out", 64'(obs_out), 64'(MO - 1));
        check("resume", 64'(obs_rdy != 0), 64'(1));

        // A stalled head requester back-pressures the divider
        do_reset();
        req_s_valid = 3'b010;
        cycle();
        req_s_valid = 3'b001;
        cycle();
        req_s_valid = '0;
        resp_m_ready = 3'b101; div_s_valid = 1'b1; div_s_data = 32'hAAAA;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("stall_dsr", 64'(obs_dsr), 64'(0));
            check("stall_out", 64'(obs_out), 64'(2));
        end
        resp_m_ready = '1;
        cycle();
        check("rel_vld", 64'(obs_rv), 64'(3'b010));
        div_s_data = 32'hBBBB;
        cycle();
        check("next_vld", 64'(obs_rv), 64'(3'b001));
        div_s_valid = 1'b0;

        // Reset with tags in flight, then a stale result arrives
        do_reset();
        req_s_valid = '1;
        for (int i = 0; i < 3; i++) cycle();
        rstn = 1'b0;
        cycle();
        rstn = 1'b1; req_s_valid = '0;
        div_s_valid = 1'b1; div_s_data = 32'hDEAD;
        cycle();
        check("orph_dsr", 64'(obs_dsr), 64'(1));
        check("orph_rv", 64'(obs_rv), 64'(0));
        div_s_valid = 1'b0;
        cycle();
        check("orph_flag", 64'(obs_orph), 64'(1));
        check("orph_out", 64'(obs_out), 64'(0));
        cycle();
        check("orph_stick", 64'(obs_orph), 64'(1));

        // Simultaneous issue and return keeps the count
        do_reset();
        req_s_valid = '1;
        for (int i = 0; i < 4; i++) cycle();
        req_s_valid = 3'b001; div_s_valid = 1'b1;
        cycle();
        req_s_valid = '0; div_s_valid = 1'b0;
        cycle();
        check("pushpop", 64'(obs_out), 64'(4));

        // Random traffic against the model
        do_reset();
        for (int n = 0; n < 400; n++) begin
            req_s_valid = NR'($urandom);
            for (int i = 0; i < NR; i++) req_s_data[i*DW +: DW] = DW'($urandom);
            div_m_ready  = ($urandom_range(0, 3) != 0);
            resp_m_ready = NR'($urandom);
            div_s_valid  = (q.size() > 0) && ($urandom_range(0, 1) == 1);
            div_s_data   = DW'($urandom);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/recip_div_arbiter.md
RECIP_DIV_ARBITER -- requirements
Module: recip_div_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3, number of requesters sharing one FixedReciprocalDivider (2..8).
REQ-002 Parameter DATA_W, default 32, width of the `fixed` divisor and result words.
REQ-003 Parameter MAX_OUT, default 8, maximum outstanding divisions; power of two, 2..32.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rstn  in  1  reset, asynchronous, active-low.
REQ-006 req_s_data  in  NUM_REQ x DATA_W  per-requester divisor (z value).
REQ-007 req_s_valid  in  NUM_REQ  per-requester divisor valid.
REQ-008 req_s_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
REQ-009 resp_m_data  out  DATA_W  reciprocal result, shared by all requesters.
REQ-010 resp_m_valid  out  NUM_REQ  per-requester result valid; one-hot or zero.
REQ-011 resp_m_ready  in  NUM_REQ  per-requester result accept.
REQ-012 div_m_data / div_m_valid  out  DATA_W / 1  divisor to the divider.
REQ-013 div_m_ready  in  1  divider accepts a divisor.
REQ-014 div_s_data / div_s_valid  in  DATA_W / 1  result from the divider.
REQ-015 div_s_ready  out  1  result accept to the divider.
REQ-016 outstanding  out  $clog2(MAX_OUT)+1  number of issued, unreturned divisions.
REQ-017 orphan_err  out  1  sticky flag: a result arrived with no outstanding tag.

Function
REQ-018 The block SHALL keep a round-robin pointer rr_ptr (0..NUM_REQ-1) and a tag FIFO of depth MAX_OUT that stores requester indices in issue order.
REQ-019 Grant (combinational): when div_m_ready=1 and the FIFO is not full, grant goes to the first i with req_s_valid[i]=1, searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ; otherwise no grant.
REQ-020 req_s_ready[i]=1 only for the granted index; div_m_valid=1 when any grant exists; div_m_data=req_s_data[granted]; zero added issue latency.
REQ-021 On issue (div_m_valid && div_m_ready), the granted index SHALL be pushed into the FIFO and rr_ptr SHALL become (granted+1) mod NUM_REQ; without an issue rr_ptr holds.
REQ-022 A full FIFO SHALL block issue even if a pop occurs in the same cycle.
REQ-023 Return path: with the FIFO non-empty and head=h, resp_m_valid[h]=div_s_valid, all other bits 0; resp_m_data=div_s_data; div_s_ready=resp_m_ready[h].
REQ-024 With the FIFO empty, resp_m_valid=0 and div_s_ready=1 (drain); any div_s_valid in that state SHALL set orphan_err, and the result is discarded.
REQ-025 On return handshake (div_s_valid && div_s_ready, FIFO non-empty) the head SHALL be popped.
REQ-026 Simultaneous push and pop SHALL leave outstanding unchanged; push-only increments it, pop-only decrements it.
REQ-027 Results SHALL be delivered in issue order; a stalled requester (resp_m_ready=0) back-pressures the divider and blocks all later results.
REQ-028 Pointer and FIFO indices SHALL wrap modulo NUM_REQ and MAX_OUT respectively, with no lost or duplicated tags.
REQ-029 orphan_err SHALL remain 1 until reset.

Reset
REQ-030 While rstn=0: rr_ptr=0, FIFO empty, outstanding=0, orphan_err=0, req_s_ready=0, div_m_valid=0, resp_m_valid=0.
REQ-031 Reset mid-operation discards all tags; divider results arriving after reset are drained under REQ-024 and set orphan_err.
REQ-032 The first grant after reset SHALL favour requester 0.

Verification
REQ-033 NUM_REQ=3, all valid continuously, div_m_ready=1, -> grant order 0,1,2,0,1,2; rr_ptr wraps to 0.
REQ-034 Req0 issues z=2.0, then req2 issues z=4.0; divider returns 0.5, then 0.25 -> resp_m_valid[0] carries 0.5, then resp_m_valid[2] carries 0.25.
REQ-035 MAX_OUT=8, issue 8 divisions with no results returned -> outstanding=8 and req_s_ready=0; one pop -> outstanding=7 and issue resumes the next cycle.
REQ-036 resp_m_ready[1]=0 with head=1 and div_s_valid=1 -> div_s_ready=0 and the FIFO holds; release -> pop, then the next tag is delivered.
REQ-037 Assert rstn=0 with 3 outstanding, release, then divider returns a result -> result drained, orphan_err=1, outstanding=0.
REQ-038 Issue and return in the same cycle at outstanding=4 -> outstanding stays 4.
